// File: rtl/alu_seq.sv
// Multi-cycle RV32-style ALU: single-cycle logic/shift/compare ops plus iterative multiply and
// optional unsigned divide/remainder behind valid/ready handshakes. Define ALU_DIV_EN for DIVU/REMU.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic [XLEN-1:0] imm_alu,
    input  logic            alu_src,
    input  logic [3:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            zero
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int SH_W  = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_MUL = 2'd1,
        ST_BUSY_DIV = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t              state_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hi_sel_q;

    logic [XLEN-1:0]     b_s;
    logic [XLEN-1:0]     single_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_work_d;
    logic [2*XLEN-1:0]   div_work_d;
    logic [2*XLEN-1:0]   final_work_s;
    logic [XLEN-1:0]     final_res_s;

    // Combinational result of every op that completes in the accept cycle; anything else yields 0.
    function automatic logic [XLEN-1:0] alu_single(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [SH_W-1:0]        sh;
        logic signed [XLEN-1:0] sa;
        logic [XLEN-1:0]        r;
        sh = b[SH_W-1:0];
        sa = $signed(a);
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a << sh;
            4'b0100: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0101: r = a ^ b;
            4'b0110: r = a - b;
            4'b0111: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b1000: r = a >> sh;
            4'b1001: r = sa >>> sh;
            default: r = {XLEN{1'b0}};
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign zero      = zero_q;

    // Operand mux, single-cycle result and one shift-add multiply step on {hi, lo} of work_q.
    always_comb begin
        b_s        = alu_src ? imm_alu : srcB;
        single_s   = alu_single(alu_control, srcA, b_s);
        mul_sum_s  = {1'b0, work_q[2*XLEN-1:XLEN]}
                   + (work_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_work_d = {mul_sum_s, work_q[XLEN-1:1]};
    end

`ifdef ALU_DIV_EN
    logic [XLEN:0] div_trial_s;
    logic [XLEN:0] div_diff_s;

    // One restoring-division step: hi holds the partial remainder, lo shifts dividend out / quotient in.
    // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        div_trial_s = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_diff_s  = div_trial_s - {1'b0, mcand_q};
        if (!div_diff_s[XLEN]) begin
            div_work_d = {div_diff_s[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
        end else begin
            div_work_d = {div_trial_s[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
        end
    end
`else
    // Without the divider the step path is a plain pass-through and never selected.
    always_comb begin
        div_work_d = work_q;
    end
`endif

    // Final-iteration value and the half (low product/quotient or high product/remainder) returned.
    always_comb begin
        final_work_s = (state_q == ST_BUSY_DIV) ? div_work_d : mul_work_d;
        if (hi_sel_q) begin
            final_res_s = final_work_s[2*XLEN-1:XLEN];
        end else begin
            final_res_s = final_work_s[XLEN-1:0];
        end
    end

    // Control FSM with registered result, zero flag and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= {XLEN{1'b0}};
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            mcand_q     <= {XLEN{1'b0}};
            work_q      <= {(2*XLEN){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            hi_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (alu_control)
                            4'b1010, 4'b1011: begin
                                work_q   <= {{XLEN{1'b0}}, b_s};
                                mcand_q  <= srcA;
                                cnt_q    <= {CNT_W{1'b0}};
                                hi_sel_q <= alu_control[0];
                                state_q  <= ST_BUSY_MUL;
                            end
`ifdef ALU_DIV_EN
                            4'b1100, 4'b1101: begin
                                work_q   <= {{XLEN{1'b0}}, srcA};
                                mcand_q  <= b_s;
                                cnt_q    <= {CNT_W{1'b0}};
                                hi_sel_q <= alu_control[0];
                                state_q  <= ST_BUSY_DIV;
                            end
`endif
                            default: begin
                                result_q    <= single_s;
                                zero_q      <= (single_s == {XLEN{1'b0}});
                                out_valid_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_BUSY_MUL, ST_BUSY_DIV: begin
                    // The last iteration loads the result directly so out_valid lands XLEN+1 cycles after accept.
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_q    <= final_res_s;
                        zero_q      <= (final_res_s == {XLEN{1'b0}});
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        work_q <= final_work_s;
                        cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against an arithmetic model,
// backpressure and mid-iteration reset.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] imm_alu;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .srcA(srcA), .srcB(srcB), .imm_alu(imm_alu), .alu_src(alu_src),
        .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the op table using wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint unsigned prod;
        int              sa;
        int unsigned     sh;
        prod = longint'(a) * longint'(b);
        sa   = a;
        sh   = b % 32;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a << sh;
            4'd4:    return (sa < int'(b)) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return a >> sh;
            4'd9:    return sa >>> sh;
            4'd10:   return prod[31:0];
            4'd11:   return prod[63:32];
            4'd12:   return !DIV_EN ? 32'd0 : (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return !DIV_EN ? 32'd0 : (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        if (op == 4'd10 || op == 4'd11) return 33;
        if ((op == 4'd12 || op == 4'd13) && DIV_EN) return 33;
        return 1;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int          lat;
        logic [31:0] held;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; alu_control = op; srcA = a; srcB = b; imm_alu = imm; alu_src = src;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        srcA = $urandom; srcB = $urandom; imm_alu = $urandom; alu_src = $urandom_range(0, 1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", ALUResult, exp_res);
        check("zero", {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        held = ALUResult;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_result", ALUResult, held);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb, ri;
        logic        rs;

        rst = 1'b1; in_valid = 1'b0; srcA = 32'd0; srcB = 32'd0; imm_alu = 32'd0;
        alu_src = 1'b0; alu_control = 4'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd2, 32'd5, 32'd99, 32'd7, 1'b1, 32'd12, 1, 0);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1, 1, 0);
        run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1, 0);
        run_op(4'd9, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'hF800_0000, 1, 0);
        run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 32'd0, 33, 0);
        run_op(4'd11, 32'h0001_0000, 32'd0, 32'h0001_0000, 1'b1, 32'd1, 33, 0);
        run_op(4'd12, 32'd100, 32'd7, 32'd0, 1'b0, DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 33 : 1, 0);
        run_op(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, DIV_EN ? 32'd2 : 32'd0, DIV_EN ? 33 : 1, 0);
        run_op(4'd12, 32'd9, 32'd0, 32'd0, 1'b0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 33 : 1, 0);
        run_op(4'd13, 32'd9, 32'd0, 32'd0, 1'b0, DIV_EN ? 32'd9 : 32'd0, DIV_EN ? 33 : 1, 0);
        run_op(4'd14, 32'd3, 32'd4, 32'd0, 1'b0, 32'd0, 1, 0);
        run_op(4'd5, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 32'h0325_4769, 1, 10);

        // Reset arrives part-way through a multiply.
        @(negedge clk);
        in_valid = 1'b1; alu_control = 4'd10; srcA = 32'h0001_0000; srcB = 32'h0001_0000; alu_src = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd2, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 1, 0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            ri = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 5) == 0) ri = 32'($urandom_range(1, 40));
            if ($urandom_range(0, 5) == 0) ra = 32'hFFFF_FFFF;
            run_op(op, ra, rb, ri, rs, ref_result(op, ra, rs ? ri : rb), ref_lat(op),
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
